// File: rtl/spi_word_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_rx_if
//  Purpose  : Bundles the SPI pins and the word-side handshake of
//             spi_word_rx. The slave modport is the receiver's view and the
//             master modport is the view of whatever drives the SPI pins
//             and consumes the words.
//  Signals  : spi_cs_l, spi_sclk, spi_data   SPI pins (master -> slave)
//             dout[DATA_W], dout_valid       received word (slave -> master)
//             dout_ready, overrun_clr        consumer controls (master -> slave)
//             bit_count[5], busy,
//             frame_err, overrun             status (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface spi_word_rx_if #(
   parameter int DATA_W = 16
) ();
   logic              spi_cs_l;
   logic              spi_sclk;
   logic              spi_data;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              overrun_clr;
   logic [4:0]        bit_count;
   logic              busy;
   logic              frame_err;
   logic              overrun;

   modport slave (
      input  spi_cs_l, spi_sclk, spi_data, dout_ready, overrun_clr,
      output dout, dout_valid, bit_count, busy, frame_err, overrun
   );

   modport master (
      output spi_cs_l, spi_sclk, spi_data, dout_ready, overrun_clr,
      input  dout, dout_valid, bit_count, busy, frame_err, overrun
   );
endinterface
`default_nettype wire

// File: rtl/spi_word_rx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_rx
//  Purpose  : SPI slave receiver for fixed-length MSB-first words. The SPI
//             pins are oversampled by clk through a synchroniser; each
//             synchronised sclk rising edge shifts one bit. A completed word
//             goes to a one-entry holding register with a valid/ready
//             handshake; a word that finds the register full is dropped and
//             flagged in the sticky overrun bit.
//  Ports    : clk         system clock, rising edge
//             reset       synchronous active-high reset
//             bus         spi_word_rx_if.slave (SPI pins, dout handshake,
//                         overrun_clr, bit_count, busy, frame_err, overrun)
//  Revision : 1.0  initial release
// ============================================================================
module spi_word_rx #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   spi_word_rx_if.slave bus
);

   localparam logic [4:0] c_data_w = 5'(DATA_W);
   localparam logic [4:0] c_last   = 5'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchroniser plus one extra sclk flop for edge detection.
   // All three pins share the same depth so data stays aligned to sclk.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_sclk_dly;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '0;
         r_data_sync <= '0;
         r_sclk_dly  <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_l};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.spi_data};
         r_sclk_dly  <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   logic w_cs_l;
   logic w_data;
   logic w_sclk_rise;

   assign w_cs_l      = r_cs_sync[SYNC_STAGES-1];
   assign w_data      = r_data_sync[SYNC_STAGES-1];
   assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_dly;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_sr;
   logic [DATA_W-1:0] w_sr_nxt;
   logic [4:0]        r_cnt;
   logic [4:0]        w_cnt_nxt;
   logic              w_word_done;
   logic              w_frame_err_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_sr_nxt        = r_sr;
      w_cnt_nxt       = r_cnt;
      w_word_done     = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Hold the datapath cleared so SHIFT is entered from zero.
            w_sr_nxt  = '0;
            w_cnt_nxt = '0;
            if (!w_cs_l) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // The completing edge takes priority over a simultaneous
            // cs_l release, so a word that just made it is still delivered.
            if (w_sclk_rise && (r_cnt == c_last)) begin
               w_sr_nxt    = {r_sr[DATA_W-2:0], w_data};
               w_cnt_nxt   = c_data_w;
               w_word_done = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_cs_l) begin
               w_frame_err_nxt = (r_cnt != 5'd0);
               w_sr_nxt        = '0;
               w_cnt_nxt       = '0;
               w_state_nxt     = S_IDLE;
            end else if (w_sclk_rise) begin
               w_sr_nxt  = {r_sr[DATA_W-2:0], w_data};
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         S_DONE: begin
            // Surplus sclk edges after a full word are ignored.
            if (w_cs_l) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Holding register, overrun and frame_err
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_valid;
   logic              r_overrun;
   logic              r_frame_err;
   logic              w_drain;

   assign w_drain = r_dout_valid & bus.dout_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err_nxt;
         if (w_word_done && (!r_dout_valid || w_drain)) begin
            r_dout       <= w_sr_nxt;
            r_dout_valid <= 1'b1;
         end else if (w_drain) begin
            r_dout_valid <= 1'b0;
         end
         // Setting has priority over clearing so no drop is ever lost.
         if (w_word_done && r_dout_valid && !w_drain) begin
            r_overrun <= 1'b1;
         end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.bit_count  = r_cnt;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.frame_err  = r_frame_err;
   assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/spi_word_rx.md
SPI_WORD_RX -- requirements
Module: spi_word_rx

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set frame length and dout width, legal 2..31.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flop count of the input synchroniser applied equally to spi_cs_l, spi_sclk and spi_data, legal >=2.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 spi_cs_l  in  1  active-low frame select from the SPI master.
REQ-006 spi_sclk  in  1  SPI serial clock; data is sampled on its rising edge.
REQ-007 spi_data  in  1  serial data, MSB first.
REQ-008 dout  out  DATA_W  received word.
REQ-009 dout_valid  out  1  dout holds an unconsumed word.
REQ-010 dout_ready  in  1  consumer accepts dout when dout_valid&dout_ready.
REQ-011 overrun_clr  in  1  clears overrun.
REQ-012 bit_count  out  5  bits shifted into the current frame, 0..DATA_W.
REQ-013 busy  out  1  high in SHIFT or DONE.
REQ-014 frame_err  out  1  one-cycle pulse on a short frame.
REQ-015 overrun  out  1  sticky: a completed word was dropped.

Function
REQ-016 Inputs SHALL pass SYNC_STAGES flops; edge detect SHALL use one extra flop on the synchronised sclk (sclk_rise = synced & ~delayed); all state decisions SHALL use synchronised values only.
REQ-017 Correct reception SHALL be guaranteed when spi_sclk high and low phases each last >=1 clk period and all three inputs change only on clk edges.
REQ-018 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-019 IDLE->SHIFT when synced cs_l is low; shift register and bit_count SHALL be 0 on entry.
REQ-020 In SHIFT, each sclk_rise SHALL shift synced data into the LSB (sr <= {sr[DATA_W-2:0], data}) and increment bit_count.
REQ-021 On the sclk_rise that makes bit_count = DATA_W, the word SHALL be offered to the holding register and FSM SHALL go to DONE.
REQ-022 Holding register SHALL load if empty or drained in the same cycle (dout_valid&dout_ready); dout_valid SHALL then be high on the next cycle.
REQ-023 If the holding register is full and not draining, the new word SHALL be dropped, dout unchanged, overrun set to 1.
REQ-024 dout and dout_valid SHALL remain stable until dout_valid&dout_ready; dout_valid SHALL clear the cycle after acceptance unless a new word loads simultaneously.
REQ-025 In SHIFT, synced cs_l high with 0<bit_count<DATA_W SHALL pulse frame_err for one cycle, discard partial data, go to IDLE, clear bit_count.
REQ-026 In SHIFT, synced cs_l high with bit_count=0 SHALL return to IDLE without frame_err.
REQ-027 cs_l rising and the completing sclk_rise in the same cycle: completion SHALL win; word delivered, no frame_err; DONE exits to IDLE next cycle.
REQ-028 In DONE, sclk_rise SHALL be ignored; synced cs_l high SHALL go to IDLE and clear bit_count.
REQ-029 overrun SHALL clear on overrun_clr; a simultaneous set SHALL win over clear.
REQ-030 busy SHALL be combinationally (state != IDLE).

Reset
REQ-031 While reset is high on a clk edge: FSM=IDLE, shift register=0, dout=0, dout_valid=0, bit_count=0, frame_err=0, overrun=0, busy=0, synchroniser flops set to cs_l=1, sclk=0, data=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without frame_err; reception SHALL restart on the next cs_l high-to-low after reset release (a frame already in progress with cs_l low SHALL be entered from IDLE at bit_count=0 and completes only if DATA_W further edges arrive).

Verification
REQ-033 reset high 2 cycles -> dout=16'h0000, dout_valid=0, bit_count=0, busy=0, frame_err=0, overrun=0.
REQ-034 one 16-bit frame 16'hA569, sclk period 2 clk, dout_ready=1 -> dout=16'hA569, dout_valid high exactly 1 cycle, bit_count=16 until cs_l high, then 0; no frame_err.
REQ-035 frames 16'hA569 then 16'h2563 with dout_ready=0 -> dout stays 16'hA569, overrun=1; dout_ready=1 -> A569 accepted, dout_valid=0 next cycle; overrun_clr -> overrun=0.
REQ-036 cs_l low, 9 sclk rises, cs_l high -> one-cycle frame_err, dout_valid stays 0, bit_count returns 0.
REQ-037 reset pulsed after 8 bits of a frame -> outputs at REQ-031 values, no frame_err; next full frame 16'h6A61 -> dout=16'h6A61.
REQ-038 frame 16'h7564 followed by a 17th sclk rise before cs_l high -> dout=16'h7564, single dout_valid, no frame_err.
